// File: rtl/cond_logic.sv
// ============================================================================
// Module   : cond_logic
// Brief    : Conditional-execution stage. Holds NZCV, evaluates Cond, gates
//            the decode write strobes. Optional macro: COND_LOGIC_UNDEF_TRAP_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_logic #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
`ifdef COND_LOGIC_UNDEF_TRAP_EN
    output logic       CondUndef,
`endif
    output logic       CondEx
);

    localparam logic [3:0] c_COND_EQ = 4'b0000;
    localparam logic [3:0] c_COND_NE = 4'b0001;
    localparam logic [3:0] c_COND_CS = 4'b0010;
    localparam logic [3:0] c_COND_CC = 4'b0011;
    localparam logic [3:0] c_COND_MI = 4'b0100;
    localparam logic [3:0] c_COND_PL = 4'b0101;
    localparam logic [3:0] c_COND_VS = 4'b0110;
    localparam logic [3:0] c_COND_VC = 4'b0111;
    localparam logic [3:0] c_COND_HI = 4'b1000;
    localparam logic [3:0] c_COND_LS = 4'b1001;
    localparam logic [3:0] c_COND_GE = 4'b1010;
    localparam logic [3:0] c_COND_LT = 4'b1011;
    localparam logic [3:0] c_COND_GT = 4'b1100;
    localparam logic [3:0] c_COND_LE = 4'b1101;
    localparam logic [3:0] c_COND_AL = 4'b1110;

    logic [3:0] r_flags;
    logic       r_cond_ex_d;
    logic       w_cond_ex;
    logic [1:0] w_flag_write;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Unlisted encodings (1111, or unknown Cond) resolve to never-execute
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            c_COND_EQ: w_cond_ex = w_z;
            c_COND_NE: w_cond_ex = ~w_z;
            c_COND_CS: w_cond_ex = w_c;
            c_COND_CC: w_cond_ex = ~w_c;
            c_COND_MI: w_cond_ex = w_n;
            c_COND_PL: w_cond_ex = ~w_n;
            c_COND_VS: w_cond_ex = w_v;
            c_COND_VC: w_cond_ex = ~w_v;
            c_COND_HI: w_cond_ex = w_c & ~w_z;
            c_COND_LS: w_cond_ex = ~w_c | w_z;
            c_COND_GE: w_cond_ex = ~(w_n ^ w_v);
            c_COND_LT: w_cond_ex = w_n ^ w_v;
            c_COND_GT: w_cond_ex = ~w_z & ~(w_n ^ w_v);
            c_COND_LE: w_cond_ex = w_z | (w_n ^ w_v);
            c_COND_AL: w_cond_ex = 1'b1;
            default:   w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_write = FlagW & {2{w_cond_ex}};

    // Flags written here are only seen by the next instruction's evaluation
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags     <= FLAGS_RESET;
            r_cond_ex_d <= 1'b0;
        end else begin
            if (w_flag_write[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flag_write[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
            r_cond_ex_d <= w_cond_ex;
        end
    end

`ifdef COND_LOGIC_UNDEF_TRAP_EN
    logic r_cond_undef;
    logic w_any_req;

    assign w_any_req = (|FlagW) | PCS | RegW | MemW;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cond_undef <= 1'b0;
        end else begin
            r_cond_undef <= (Cond == 4'b1111) & w_any_req;
        end
    end

    assign CondUndef = r_cond_undef;
`endif

    assign PCWrite  = (PCS & r_cond_ex_d) | NextPC;
    assign RegWrite = RegW & r_cond_ex_d;
    assign MemWrite = MemW & r_cond_ex_d;
    assign Flags    = r_flags;
    assign CondEx   = w_cond_ex;

endmodule

`default_nettype wire

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage of the multicycle ARM datapath, directly downstream of the instruction decode/main-FSM block.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it.
- Gates the decode-side write strobes (PCS, RegW, MemW) into the committed datapath strobes: PCWrite, RegWrite and MemWrite.
- Updates the flags from the ALU under FlagW control, only when the instruction's condition passes.

Parameters:
- FLAGS_RESET, 4'b0000, reset value of the NZCV register, order {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- Cond  input  4  condition field Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU this cycle.
- FlagW  input  2  flag write request from decode: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  decode: instruction writes PC (branch or Rd=R15 with RegW).
- NextPC  input  1  main FSM: unconditional PC+4 update (fetch).
- RegW  input  1  main FSM register-write request.
- MemW  input  1  main FSM memory-write request.
- PCWrite  output  1  committed PC write enable.
- RegWrite  output  1  committed register-file write enable.
- MemWrite  output  1  committed data-memory write enable.
- Flags  output  4  current NZCV register contents.
- CondEx  output  1  combinational condition result against the current Flags.

Behaviour:
- Reset (reset==0 at a rising edge): Flags<=FLAGS_RESET; CondExDelayed<=0. Therefore PCWrite=NextPC, and RegWrite=MemWrite=0 until the first post-reset edge.
- Condition evaluation is combinational from Cond and the registered Flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0
- FlagWrite[1:0] = FlagW & {2{CondEx}}.
- At each rising edge with reset==1:
  - If FlagWrite[1]: Flags[3:2]<=ALUFlags[3:2].
  - If FlagWrite[0]: Flags[1:0]<=ALUFlags[1:0].
  - A field not selected holds its value.
- CondExDelayed<=CondEx on every edge. One-cycle latency: the condition evaluated in Execute, with pre-update flags, gates the following writeback/memory cycle.
- Outputs, all combinational from the registered state:
  - PCWrite = (PCS & CondExDelayed) | NextPC
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- Simultaneous events:
  - An instruction that both sets flags and is conditional tests the OLD flags; the new flags are visible from the next cycle.
  - NextPC forces PCWrite regardless of condition.
- A failed condition suppresses the flag update and all three write strobes of that instruction. NextPC is unaffected.
- Reset asserted mid-instruction: state is cleared at that edge; pending strobes drop on the next cycle.
- No X propagation: FlagW, PCS, RegW and MemW at 0 produce deterministic 0 strobes even when Cond is unknown.

Optional Feature:
- Macro COND_LOGIC_UNDEF_TRAP_EN.
- Defined:
  - Adds output CondUndef (1 bit, registered, reset 0).
  - CondUndef is set for exactly one cycle after any cycle in which Cond==4'b1111 and any of FlagW, PCS, RegW or MemW is nonzero.
  - Flag and write suppression are unchanged.
- Undefined: the port is absent, and Cond 1111 silently evaluates to never-execute.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then release → Flags=0000, RegWrite=MemWrite=0, PCWrite follows NextPC.
- Flag update: Cond=1110, FlagW=11, ALUFlags=0100 for one edge → Flags=0100. Then FlagW=01, ALUFlags=1011 → Flags=0111 (NZ held, CV updated).
- Conditional suppression:
  - Flags=0100, Cond=0001 (NE), RegW=1 in the next cycle → RegWrite=0.
  - Same sequence with Cond=0000 (EQ) → RegWrite=1 one cycle after evaluation.
- Branch:
  - Flags=1000, Cond=1011 (LT, N!=V), PCS=1 → PCWrite=1 in the delayed cycle.
  - Flags=1001 → PCWrite=0.
  - NextPC=1 with CondExDelayed=0 → PCWrite=1.
- Old-flag semantics: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=0100 → CondEx=0, Flags stay 0000, MemWrite=0 for MemW=1.
- Trap (macro on): Cond=1111, RegW=1 → CondUndef=1 for one cycle, RegWrite=0. Cond=1111 with all requests 0 → CondUndef=0.
